addern_seq_ctrl: RTL and testbench
==================================

Name: addern_seq_ctrl

Overview:
- Sequencing controller that performs one wide add or subtract of width N*K using a single external N-bit adder slice (the Addern slice: Cin, X, Y -> Sum, Cout).
- Processes one slice per clock, least-significant first, and ripples the carry through an internal register.
- Provides a Start/Busy/Done handshake to the surrounding demo logic, and holds the result until the next accepted Start.

Parameters:
- N, 4, adder slice width in bits
- K, 4, number of slices; operand/result width is N*K (K >= 1)

Ports:
- Clock  input  1  system clock, rising edge
- Resetn  input  1  asynchronous active-low reset
- Start  input  1  request operation; sampled only in IDLE
- Sub  input  1  0 = A+B, 1 = A-B; captured with Start
- A  input  N*K  operand A; captured with Start
- B  input  N*K  operand B; captured with Start
- AddX  output  N  slice X to adder
- AddY  output  N  slice Y to adder
- AddCin  output  1  slice carry-in to adder
- AddSum  input  N  slice sum from adder (combinational)
- AddCout  input  1  slice carry-out from adder
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse when Result is valid
- Result  output  N*K  registered result
- Cout  output  1  final carry-out; for Sub, 1 = no borrow
- Ovf  output  1  signed two's-complement overflow of the last operation

Behaviour:
- Reset is asynchronous: Resetn=0 forces state IDLE and clears all registers, including mid-operation. All outputs reset to 0: Busy, Done, Result, Cout, Ovf, AddX, AddY, AddCin. The aborted operation is discarded and no Done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on a rising edge with Start=1:
  - A_r is loaded from A.
  - B_r is loaded with B when Sub=0, or with ~B when Sub=1.
  - carry_r is loaded with Sub.
  - Slice index i is set to 0.
- In RUN, outputs are driven combinationally from registers:
  - AddX = A_r[i*N +: N]
  - AddY = B_r[i*N +: N]
  - AddCin = carry_r
- Each edge in RUN:
  - Result[i*N +: N] <= AddSum.
  - carry_r <= AddCout.
  - When i == K-1, go to DONE. Otherwise i <= i+1.
- On the last slice (i == K-1), in the same edge:
  - Cout <= AddCout.
  - Ovf <= AddCout ^ (AddSum[N-1] ^ AddX[N-1] ^ AddY[N-1]), i.e. the carry into the MSB xor the carry out.
- DONE lasts exactly one cycle: Done=1, Busy=0, then IDLE unconditionally.
- AddX, AddY and AddCin are 0 outside RUN.
- Latency: Start sampled at edge 0; RUN occupies cycles 1..K; Done is high in cycle K+1. Back-to-back throughput is one operation per K+2 cycles.
- Start is ignored in RUN and in DONE. There is no queueing, and the A, B and Sub inputs may change freely after capture.
- Result, Cout and Ovf hold from DONE until the next accepted Start. Slices of Result are overwritten progressively during RUN, so Result is valid only from Done onward.
- Arithmetic is modulo 2^(N*K). Cout is the unsigned carry out (unsigned overflow for add, no-borrow for sub). Ovf follows signed interpretation.
- K=1 degenerates to a single RUN cycle.
- The index counter is wide enough to hold K-1 ($clog2(K), minimum 1 bit). It never wraps past K-1.

Test Plan (N=4, K=4, checked against a reference model, Addern slice connected):
- A=0x00FF, B=0x0001, Sub=0, Start pulse -> Busy high 4 cycles; Done in cycle 5; Result=0x0100, Cout=0, Ovf=0; AddCin trace per slice 0,1,1,0.
- A=0xFFFF, B=0x0001, Sub=0 -> Result=0x0000, Cout=1, Ovf=0. A=0x7FFF, B=0x0001 -> Result=0x8000, Cout=0, Ovf=1.
- Sub: A=0x0005, B=0x0007, Sub=1 -> Result=0xFFFE, Cout=0, Ovf=0. A=0x8000, B=0x0001, Sub=1 -> Result=0x7FFF, Cout=1, Ovf=1.
- Start held high continuously with changing A/B -> operations accepted only in IDLE, one per 6 cycles. Each Result matches the operands captured at its accepting edge; mid-RUN input changes have no effect.
- Resetn pulsed low during RUN cycle 2 -> all outputs 0 immediately (asynchronously); no Done pulse. Next Start after release completes normally with correct Result.
- Random regression: 1000 random A/B/Sub with random Start gaps -> Result, Cout and Ovf match the model; Done is exactly one cycle per accepted Start.

Source files
------------

// File: rtl/addern_seq_ctrl.sv
// Sequencing controller that performs one N*K-bit add or subtract by stepping
// an external N-bit adder slice through K slices, least-significant first.
module addern_seq_ctrl #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    output logic [N-1:0]   addx,
    output logic [N-1:0]   addy,
    output logic           addcin,
    input  logic [N-1:0]   addsum,
    input  logic           addcout,
    output logic           busy,
    output logic           done,
    output logic [N*K-1:0] result,
    output logic           cout,
    output logic           ovf
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N*K-1:0] a_r;
    logic [N*K-1:0] b_r;
    logic           carry_r;
    logic [IW-1:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Slice operands are presented only while running so the adder sees zeros when idle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        addx       = '0;
        addy       = '0;
        addcin     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                addcin = carry_r;
                for (int s = 0; s < K; s++) begin
                    if (idx == IW'(s)) begin
                        addx = a_r[s*N +: N];
                        addy = b_r[s*N +: N];
                    end
                end
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1: the inverted operand and the seeded carry do the work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    for (int s = 0; s < K; s++) begin
                        if (idx == IW'(s)) begin
                            result[s*N +: N] <= addsum;
                        end
                    end
                    carry_r <= addcout;
                    if (idx == LAST) begin
                        cout <= addcout;
                        ovf  <= addcout ^ (addsum[N-1] ^ addx[N-1] ^ addy[N-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addern_seq_ctrl.sv
// Self-checking bench for addern_seq_ctrl with a behavioural N-bit adder slice
// and an arithmetic reference model of the full-width add/subtract.
module tb_addern_seq_ctrl;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           sub;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [N-1:0]   addx;
    logic [N-1:0]   addy;
    logic           addcin;
    logic [N-1:0]   addsum;
    logic           addcout;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic           ovf;

    int compared;
    int mismatched;

    addern_seq_ctrl #(.N(N), .K(K)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .addx    (addx),
        .addy    (addy),
        .addcin  (addcin),
        .addsum  (addsum),
        .addcout (addcout),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .ovf     (ovf)
    );

    // External adder slice
    assign {addcout, addsum} = {1'b0, addx} + {1'b0, addy} + {{N{1'b0}}, addcin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {cout, ovf, result} from plain W-bit arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        if (!msub) begin
            s = {1'b0, ma} + {1'b0, mb};
            r = s[W-1:0];
            c = s[W];
            o = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
        end else begin
            r = ma - mb;
            c = (ma >= mb);
            o = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        end
        return {c, o, r};
    endfunction

    // Launches one operation from IDLE (called just after a falling edge) and
    // observes it; optional noise toggles start/operands while it runs.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                         input logic noise,
                         output logic [W-1:0] res, output logic co, output logic ov,
                         output int busycnt, output int donecyc, output logic donelow,
                         output logic timedout, output logic [K-1:0] trace);
        bit seen;
        seen     = 0;
        busycnt  = 0;
        donecyc  = 0;
        donelow  = 1'b0;
        timedout = 1'b1;
        trace    = '0;
        res      = '0;
        co       = 1'b0;
        ov       = 1'b0;
        a     = oa;
        b     = ob;
        sub   = osub;
        start = 1'b1;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            if (busy) begin
                if (busycnt < K) trace[busycnt] = addcin;
                busycnt++;
            end
            if (done) begin
                seen     = 1;
                timedout = 1'b0;
                donecyc  = cyc;
                res      = result;
                co       = cout;
                ov       = ovf;
                start    = 1'b0;
            end else if (noise) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        if (seen) begin
            @(negedge clk);
            donelow = !done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b1;
        a     = 16'hABCD;
        b     = 16'h1234;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, done, cout, ovf, addcin} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, cout, ovf, addcin});
        end
        compared++;
        if ({result, addx, addy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0", {result, addx, addy});
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, done} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_idle: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] er [5] = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] res;
        logic         co, ov, dl, to;
        logic [K-1:0] tr;
        int           bc, dc;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], 1'b0, res, co, ov, bc, dc, dl, to, tr);
            compared++;
            if (to !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL dir_timeout[%0d]: got timeout=%b expected 0", i, to);
            end
            compared++;
            if ({res, co, ov} !== {er[i], ec[i], eo[i]}) begin
                mismatched++;
                $display("[TB] FAIL dir_result[%0d]: got %h c=%b o=%b expected %h c=%b o=%b",
                         i, res, co, ov, er[i], ec[i], eo[i]);
            end
            compared++;
            if (bc != K || dc != K + 1 || dl !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL dir_timing[%0d]: got busy=%0d done_at=%0d low_after=%b expected %0d %0d 1",
                         i, bc, dc, dl, K, K + 1);
            end
            if (i == 0) begin
                compared++;
                if (tr !== 4'b0110) begin
                    mismatched++;
                    $display("[TB] FAIL dir_cin_trace: got %b expected 0110", tr);
                end
            end
        end
    endtask

    // Start held high: acceptances fall every K+2 edges and use the operands of that edge
    task automatic test_back_to_back();
        logic [W-1:0] va [19];
        logic [W-1:0] vb [19];
        logic         vs [19];
        logic [W+1:0] exp;
        int           period;
        period = K + 2;
        for (int n = 0; n <= 24; n++) begin
            if (n >= 1) begin
                compared++;
                if (done !== ((n - 1) % period == K)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", n, done, ((n - 1) % period == K));
                end
                if ((n - 1) % period == K) begin
                    exp = model(va[n - 1 - K], vb[n - 1 - K], vs[n - 1 - K]);
                    compared++;
                    if ({cout, ovf, result} !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_result[%0d]: got %b_%b_%h expected %b_%b_%h",
                                 n, cout, ovf, result, exp[W+1], exp[W], exp[W-1:0]);
                    end
                end
            end
            if (n <= 18) begin
                va[n] = W'($urandom);
                vb[n] = W'($urandom);
                vs[n] = 1'($urandom_range(0, 1));
                a     = va[n];
                b     = vb[n];
                sub   = vs[n];
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (n < 24) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] res, ra, rb;
        logic         co, ov, dl, to, rs;
        logic [K-1:0] tr;
        int           bc, dc;
        logic [W+1:0] exp;
        bit           sawdone;
        a     = 16'h1357;
        b     = 16'h2468;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, done, cout, ovf, addcin, result, addx, addy} !== '0) begin
            mismatched++;
            $display("[TB] FAIL midrun_reset_async: got busy=%b done=%b res=%h x=%h y=%h expected all 0",
                     busy, done, result, addx, addy);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        sawdone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) sawdone = 1;
        end
        compared++;
        if (sawdone) begin
            mismatched++;
            $display("[TB] FAIL midrun_no_done: got done pulse expected none");
        end
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom_range(0, 1));
        do_op(ra, rb, rs, 1'b0, res, co, ov, bc, dc, dl, to, tr);
        exp = model(ra, rb, rs);
        compared++;
        if (to !== 1'b0 || {co, ov, res} !== exp) begin
            mismatched++;
            $display("[TB] FAIL midrun_recover: got to=%b %b_%b_%h expected 0 %b_%b_%h",
                     to, co, ov, res, exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] res, ra, rb;
        logic         co, ov, dl, to, rs;
        logic [K-1:0] tr;
        int           bc, dc;
        logic [W+1:0] exp;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, 1'($urandom_range(0, 1)), res, co, ov, bc, dc, dl, to, tr);
            exp = model(ra, rb, rs);
            compared++;
            if (to !== 1'b0 || {co, ov, res} !== exp) begin
                mismatched++;
                $display("[TB] FAIL rand_result[%0d]: a=%h b=%h sub=%b got to=%b %b_%b_%h expected 0 %b_%b_%h",
                         i, ra, rb, rs, to, co, ov, res, exp[W+1], exp[W], exp[W-1:0]);
            end
            compared++;
            if (bc != K || dc != K + 1 || dl !== 1'b1 || tr[0] !== rs) begin
                mismatched++;
                $display("[TB] FAIL rand_handshake[%0d]: got busy=%0d done_at=%0d low_after=%b cin0=%b expected %0d %0d 1 %b",
                         i, bc, dc, dl, tr[0], K, K + 1, rs);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        sub        = 1'b0;
        a          = '0;
        b          = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
